obi_rr_arbiter: RTL

// - Shares one OBI secondary (e.g. a CDC bridge or peripheral) between NUM_PRIM OBI primaries.
// - Round-robin arbitration; one grant per cycle; up to MAX_OUTST accepted-but-unanswered transactions.
// - Tracks grant order so each rvalid is returned to the primary that issued the transaction.
// - Single clock domain; sits between the primaries and a CDC bridge or peripheral.

---
 rtl/obi_pkg.sv | 12 +
 rtl/obi_arb_id_fifo.sv | 60 ++++++
 rtl/obi_rr_arbiter.sv | 118 +++++++++++
 3 files changed

// File: rtl/obi_pkg.sv
// OBI bus widths shared by the arbiter and the CDC blocks.
package obi_pkg;

  localparam int OBI_ADDR_W = 32;
  localparam int OBI_DATA_W = 32;
  localparam int OBI_BE_W   = 4;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/obi_arb_id_fifo.sv
// Grant-order tracker: holds the primary index of each accepted,
// not-yet-answered transaction.
module obi_arb_id_fifo #(
  parameter int W     = 1,
  parameter int DEPTH = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] head_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          push_ok, pop_ok;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rd_q];
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_comb begin
    wr_d  = push_ok ? nxt(wr_q) : wr_q;
    rd_d  = pop_ok ? nxt(rd_q) : rd_q;
    cnt_d = cnt_q;
    if (push_ok && !pop_ok) cnt_d = cnt_q + 1'b1;
    if (pop_ok && !push_ok) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_q] <= din_i;
  end

endmodule

// File: rtl/obi_rr_arbiter.sv
// Round-robin OBI arbiter: N primaries onto one secondary, with
// in-order response routing through an ID FIFO.
module obi_rr_arbiter
  import obi_pkg::*;
#(
  parameter int NUM_PRIM  = 2,
  parameter int MAX_OUTST = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NUM_PRIM-1:0]      prim_req_i,
  output logic [NUM_PRIM-1:0]      prim_gnt_o,
  input  logic [32*NUM_PRIM-1:0]   prim_addr_i,
  input  logic [NUM_PRIM-1:0]      prim_we_i,
  input  logic [4*NUM_PRIM-1:0]    prim_be_i,
  input  logic [32*NUM_PRIM-1:0]   prim_wdata_i,
  output logic [NUM_PRIM-1:0]      prim_rvalid_o,
  output logic [31:0]              prim_rdata_o,
  output logic                     sec_req_o,
  input  logic                     sec_gnt_i,
  output logic [31:0]              sec_addr_o,
  output logic                     sec_we_o,
  output logic [3:0]               sec_be_o,
  output logic [31:0]              sec_wdata_o,
  input  logic                     sec_rvalid_i,
  input  logic [31:0]              sec_rdata_i,
  output logic                     proto_err_o
);

  localparam int IDX_W = idx_width(NUM_PRIM);

  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] lock_idx_q, lock_idx_d;
  logic             lock_q, lock_d;
  logic             err_q, err_d;
  logic [IDX_W-1:0] winner, sel, head;
  logic             full, empty, accept, pop;

  always_comb begin : search
    logic [IDX_W-1:0] idx;
    int               j;
    logic             found;
    winner = rr_ptr_q;
    found  = 1'b0;
    for (int i = 0; i < NUM_PRIM; i++) begin
      j = 32'(rr_ptr_q) + i;
      if (j >= NUM_PRIM) j = j - NUM_PRIM;
      idx = IDX_W'(j);
      if (!found && prim_req_i[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  assign sel = lock_q ? lock_idx_q : winner;

  // Gated by rst_i so every handshake output drops the moment reset asserts.
  assign sec_req_o = !rst_i && prim_req_i[sel] && !full;
  assign accept    = sec_req_o && sec_gnt_i;
  assign pop       = !rst_i && sec_rvalid_i && !empty;

  assign prim_gnt_o    = accept ? (NUM_PRIM'(1) << sel) : '0;
  assign prim_rvalid_o = pop ? (NUM_PRIM'(1) << head) : '0;
  assign prim_rdata_o  = sec_rdata_i;
  assign proto_err_o   = err_q;

  assign sec_addr_o  = prim_addr_i[32'(sel)*OBI_ADDR_W +: OBI_ADDR_W];
  assign sec_we_o    = prim_we_i[sel];
  assign sec_be_o    = prim_be_i[32'(sel)*OBI_BE_W +: OBI_BE_W];
  assign sec_wdata_o = prim_wdata_i[32'(sel)*OBI_DATA_W +: OBI_DATA_W];

  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    err_d      = err_q || (sec_rvalid_i && empty);
    if (accept) begin
      rr_ptr_d = (sel == IDX_W'(NUM_PRIM - 1)) ? '0 : sel + 1'b1;
      lock_d   = 1'b0;
    end else if (sec_req_o) begin
      lock_d     = 1'b1;
      lock_idx_d = sel;
    end else if (!full) begin
      // Locked primary dropped its request: release and re-arbitrate.
      lock_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr_q   <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      err_q      <= 1'b0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      err_q      <= err_d;
    end
  end

  obi_arb_id_fifo #(
    .W     (IDX_W),
    .DEPTH (MAX_OUTST)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (accept),
    .pop_i   (pop),
    .din_i   (sel),
    .head_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );

endmodule
